keypad_scan_controller: RTL

- Sequences the 4x4 active-low membrane keypad used by the memorization game.
- Drives the column strobes one at a time and waits for the lines to settle before sampling the rows.
- Debounces each press and its release, and emits one key event per physical press.
- Assembles DIGITS digits into a packed entry word and hands it to the game FSM with a valid/ack handshake.

---
 rtl/keypad_scan_controller.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_controller.sv
// keypad_scan_controller
//   Scans a 4x4 active-low membrane keypad one column at a time, debounces
//   each press and its release, emits one key event per physical press and
//   assembles DIGITS decimal digits into an entry word that is handed to the
//   game FSM through a valid/ack handshake.
//
// Ports
//   masterClk    in   system clock, all state changes on the rising edge
//   rst          in   synchronous reset, active-high
//   en           in   scanning enable; low parks the scanner with columns off
//   row[3:0]     in   keypad rows, active-low, row[3] is the top row
//   col[3:0]     out  column strobes, active-low, col[0] is the left column
//   key_code     out  code of the last debounced key (4'hF after reset)
//   key_valid    out  one-cycle pulse per debounced press
//   entry        out  packed digits, newest in [3:0], empty nibbles 4'hF
//   entry_count  out  number of digits currently held
//   entry_valid  out  entry complete, held until entry_ack
//   entry_ack    in   game FSM has consumed the entry
module keypad_scan_controller #(
  parameter int SETTLE_CYCLES   = 1000,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int DIGITS          = 4
) (
  input  logic                  masterClk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [3:0]            row,
  output logic [3:0]            col,
  output logic [3:0]            key_code,
  output logic                  key_valid,
  output logic [4*DIGITS-1:0]   entry,
  output logic [3:0]            entry_count,
  output logic                  entry_valid,
  input  logic                  entry_ack
);

  localparam int MAXC = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SETTLE_LAST   = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DEBOUNCE_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    DIGITS_C      = 4'(DIGITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_DEBOUNCE,
    S_PRESS,
    S_RELEASE
  } state_t;

  state_t                r_state;
  logic [1:0]            r_idx;
  logic [CW-1:0]         r_cnt;
  logic [3:0]            r_row_lat;
  logic [3:0]            r_col;
  logic [3:0]            r_key_code;
  logic                  r_key_valid;
  logic [4*DIGITS-1:0]   r_entry;
  logic [3:0]            r_count;
  logic                  r_entry_valid;

  logic [1:0]            w_idx_next;
  logic                  w_one_low;
  logic [3:0]            w_key;
  logic [4*DIGITS-1:0]   w_entry_shift;

  // One-cold strobe for a column index.
  function automatic logic [3:0] col_strobe(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // A usable sample has exactly one row pulled low.
  function automatic logic one_row_low(input logic [3:0] rp);
    logic ok;
    case (rp)
      4'b0111, 4'b1011, 4'b1101, 4'b1110: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Column index plus latched row pattern to key code. row[3] is row 0.
  function automatic logic [3:0] key_map(input logic [1:0] idx, input logic [3:0] rp);
    logic [1:0] r;
    logic [3:0] k;
    case (rp)
      4'b0111: r = 2'd0;
      4'b1011: r = 2'd1;
      4'b1101: r = 2'd2;
      default: r = 2'd3;
    endcase
    case ({idx, r})
      4'h0: k = 4'h1;  4'h1: k = 4'h4;  4'h2: k = 4'h7;  4'h3: k = 4'h0;
      4'h4: k = 4'h2;  4'h5: k = 4'h5;  4'h6: k = 4'h8;  4'h7: k = 4'hF;
      4'h8: k = 4'h3;  4'h9: k = 4'h6;  4'hA: k = 4'h9;  4'hB: k = 4'hE;
      4'hC: k = 4'hA;  4'hD: k = 4'hB;  4'hE: k = 4'hC;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  assign w_idx_next    = r_idx + 2'd1;
  assign w_one_low     = one_row_low(row);
  assign w_key         = key_map(r_idx, r_row_lat);
  // Shift form keeps DIGITS=1 legal (no negative part-select bound).
  assign w_entry_shift = (r_entry << 4) | (4*DIGITS)'(w_key);

  always_ff @(posedge masterClk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_idx         <= 2'd0;
      r_cnt         <= '0;
      r_row_lat     <= 4'hF;
      r_col         <= 4'hF;
      r_key_code    <= 4'hF;
      r_key_valid   <= 1'b0;
      r_entry       <= '1;
      r_count       <= 4'd0;
      r_entry_valid <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;

      // Handshake is independent of the scanner state; ack without a
      // pending entry is ignored.
      if (entry_ack && r_entry_valid) begin
        r_entry       <= '1;
        r_count       <= 4'd0;
        r_entry_valid <= 1'b0;
      end

      if (!en) begin
        r_state <= S_IDLE;
        r_col   <= 4'hF;
        r_cnt   <= '0;
        r_idx   <= 2'd0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (!r_entry_valid) begin
              r_state <= S_DRIVE;
              r_idx   <= 2'd0;
              r_col   <= col_strobe(2'd0);
              r_cnt   <= '0;
            end
          end
          S_DRIVE: begin
            if (r_cnt == SETTLE_LAST) begin
              r_cnt <= '0;
              if (w_one_low) begin
                r_row_lat <= row;
                r_state   <= S_DEBOUNCE;
              end else begin
                r_idx <= w_idx_next;
                r_col <= col_strobe(w_idx_next);
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_DEBOUNCE: begin
            // Any change restarts settling on the same column.
            if (row != r_row_lat) begin
              r_state <= S_DRIVE;
              r_cnt   <= '0;
            end else if (r_cnt == DEBOUNCE_LAST) begin
              r_state <= S_PRESS;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_PRESS: begin
            r_key_valid <= 1'b1;
            r_key_code  <= w_key;
            if (w_key <= 4'd9 && r_count < DIGITS_C) begin
              r_entry <= w_entry_shift;
              r_count <= r_count + 4'd1;
              if (r_count + 4'd1 == DIGITS_C) r_entry_valid <= 1'b1;
            end else if (w_key == 4'hE) begin
              r_entry <= '1;
              r_count <= 4'd0;
            end
            r_state <= S_RELEASE;
            r_cnt   <= '0;
          end
          S_RELEASE: begin
            // Release needs an unbroken run of all-high samples.
            if (row != 4'hF) begin
              r_cnt <= '0;
            end else if (r_cnt == DEBOUNCE_LAST) begin
              r_cnt <= '0;
              if (r_entry_valid) begin
                r_state <= S_IDLE;
                r_col   <= 4'hF;
              end else begin
                r_state <= S_DRIVE;
                r_idx   <= w_idx_next;
                r_col   <= col_strobe(w_idx_next);
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_col   <= 4'hF;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign col         = r_col;
  assign key_code    = r_key_code;
  assign key_valid   = r_key_valid;
  assign entry       = r_entry;
  assign entry_count = r_count;
  assign entry_valid = r_entry_valid;

endmodule
